// File: rtl/firebird7_in_gate1_tessent_data_mux_tdr.sv
// IJTAG test data register driving a per-channel data mux with freeze.
// Selects and freeze are shifted in, then applied together on update.
module firebird7_in_gate1_tessent_data_mux_tdr #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned CHANNELS = 4,
  parameter logic [CHANNELS-1:0] RESET_SEL = '0
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  input  logic ijtag_sel,
  input  logic ijtag_ce,
  input  logic ijtag_se,
  input  logic ijtag_ue,
  input  logic ijtag_si,
  output logic ijtag_so,
  input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
  input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0] sel_status
);

  localparam int unsigned L = CHANNELS + 1;
  localparam logic [L-1:0] RST_VAL = {1'b0, RESET_SEL};

  logic [L-1:0] sr;
  logic [L-1:0] ur;
  logic [CHANNELS*WIDTH-1:0] hold;
  logic [CHANNELS*WIDTH-1:0] mux;
  logic freeze;

  logic do_cap;
  logic do_shift;
  logic do_upd;

  assign do_cap   = ijtag_sel & ijtag_ce;
  assign do_shift = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign do_upd   = ijtag_sel & ijtag_ue;
  assign freeze   = ur[CHANNELS];

  // Per-channel live mux between functional and IJTAG data.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_mux
    assign mux[c*WIDTH +: WIDTH] = ur[c]
      ? ijtag_data_in[c*WIDTH +: WIDTH]
      : functional_data_in[c*WIDTH +: WIDTH];
  end

  // Shift register: capture readback has priority over shift.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr <= RST_VAL;
    end else if (do_cap) begin
      sr <= ur;
    end else if (do_shift) begin
      sr <= {ijtag_si, sr[L-1:1]};
    end
  end

  // Update register takes the pre-edge shift value.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      ur <= RST_VAL;
    end else if (do_upd) begin
      ur <= sr;
    end
  end

  // Hold tracks the live mux until freeze is applied.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      hold <= '0;
    end else if (!freeze) begin
      hold <= mux;
    end
  end

  assign data_out   = freeze ? hold : mux;
  assign sel_status = ur[CHANNELS-1:0];
  assign ijtag_so   = sr[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_tdr.sv
// Scoreboard bench for the IJTAG data mux TDR.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_firebird7_in_gate1_tessent_data_mux_tdr;

  localparam int W = 19;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic ijtag_reset;
  logic ijtag_sel;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_si;
  logic ijtag_so;
  logic [CH*W-1:0] functional_data_in;
  logic [CH*W-1:0] ijtag_data_in;
  logic [CH*W-1:0] data_out;
  logic [CH-1:0] sel_status;

  typedef struct {
    string nm;
    int kind;
    int ch;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  localparam int K_SEL = 0;
  localparam int K_SO = 1;
  localparam int K_DAT = 2;

  firebird7_in_gate1_tessent_data_mux_tdr #(
    .WIDTH(W),
    .CHANNELS(CH),
    .RESET_SEL(4'b0101)
  ) dut (
    .ijtag_tck(clk),
    .ijtag_reset(ijtag_reset),
    .ijtag_sel(ijtag_sel),
    .ijtag_ce(ijtag_ce),
    .ijtag_se(ijtag_se),
    .ijtag_ue(ijtag_ue),
    .ijtag_si(ijtag_si),
    .ijtag_so(ijtag_so),
    .functional_data_in(functional_data_in),
    .ijtag_data_in(ijtag_data_in),
    .data_out(data_out),
    .sel_status(sel_status)
  );

  always #5 clk = ~clk;

  function automatic void chk(input int kind, input int ch,
                              input logic [31:0] v, input string nm);
    item_t it;
    it.nm = nm;
    it.kind = kind;
    it.ch = ch;
    it.exp = v;
    sb.push_back(it);
  endfunction

  // Monitor: drain all pending expectations on each falling edge.
  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      act = '0;
      case (it.kind)
        K_SEL: act = 32'(sel_status);
        K_SO: act = 32'(ijtag_so);
        default: act = 32'(data_out[it.ch*W +: W]);
      endcase
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h",
                 it.nm, act, it.exp);
      end
    end
  end

  task automatic cyc(input logic ce, input logic se,
                     input logic ue, input logic si);
    ijtag_ce = ce;
    ijtag_se = se;
    ijtag_ue = ue;
    ijtag_si = si;
    @(posedge clk);
    #1;
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
    ijtag_si = 1'b0;
  endtask

  task automatic shift5(input logic [4:0] v);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, v[i]);
  endtask

  task automatic upd();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_func(input int ch, input logic [W-1:0] v);
    functional_data_in[ch*W +: W] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ijtag_reset = 1'b1;
    ijtag_sel = 1'b1;
    ijtag_ce = 1'b0;
    ijtag_se = 1'b0;
    ijtag_ue = 1'b0;
    ijtag_si = 1'b0;
    for (int c = 0; c < CH; c++) begin
      functional_data_in[c*W +: W] = 19'h11111;
      ijtag_data_in[c*W +: W] = 19'h22222;
    end
    repeat (2) @(posedge clk);
    #1;
    ijtag_reset = 1'b0;

    // Reset state.
    chk(K_SEL, 0, 32'h5, "rst_sel");
    chk(K_SO, 0, 32'h1, "rst_so");
    chk(K_DAT, 0, 32'h22222, "rst_ch0");
    chk(K_DAT, 1, 32'h11111, "rst_ch1");
    chk(K_DAT, 2, 32'h22222, "rst_ch2");
    chk(K_DAT, 3, 32'h11111, "rst_ch3");

    // Shift 1,1,0,0,0; no change before update.
    shift5(5'b00011);
    chk(K_SEL, 0, 32'h5, "preupd_sel");
    chk(K_SO, 0, 32'h1, "preupd_so");
    upd();
    chk(K_SEL, 0, 32'h3, "upd_sel");
    chk(K_DAT, 0, 32'h22222, "upd_ch0");
    chk(K_DAT, 1, 32'h22222, "upd_ch1");
    chk(K_DAT, 2, 32'h11111, "upd_ch2");
    chk(K_DAT, 3, 32'h11111, "upd_ch3");

    // Freeze sequence.
    set_func(0, 19'h0ABCD);
    shift5(5'b00000);
    upd();
    chk(K_SEL, 0, 32'h0, "sel0_sel");
    chk(K_DAT, 0, 32'h0ABCD, "sel0_ch0");
    shift5(5'b10000);
    upd();
    set_func(0, 19'h12345);
    chk(K_SEL, 0, 32'h0, "frz_sel");
    chk(K_DAT, 0, 32'h0ABCD, "frz_ch0");
    chk(K_DAT, 1, 32'h11111, "frz_ch1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk(K_DAT, 0, 32'h0ABCD, "frz_hold_ch0");
    shift5(5'b10001);
    upd();
    chk(K_SEL, 0, 32'h1, "frz_newsel");
    chk(K_DAT, 0, 32'h0ABCD, "frz_newsel_ch0");
    shift5(5'b00000);
    upd();
    chk(K_SEL, 0, 32'h0, "unfrz_sel");
    chk(K_DAT, 0, 32'h12345, "unfrz_ch0");

    // Capture readback of 5'b10110.
    shift5(5'b10110);
    upd();
    chk(K_SEL, 0, 32'h6, "cap_cfg_sel");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h0, "cap_so0");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h1, "cap_so1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h1, "cap_so2");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h0, "cap_so3");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h1, "cap_so4");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h0, "cap_so5");

    // ce and se together: capture wins.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk(K_SO, 0, 32'h0, "cese_so");
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h1, "cese_next_so");

    // ue and se together: update takes pre-shift sr.
    shift5(5'b00101);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk(K_SEL, 0, 32'h5, "uese_sel");
    chk(K_SO, 0, 32'h0, "uese_so");
    chk(K_DAT, 0, 32'h22222, "uese_ch0");
    chk(K_DAT, 1, 32'h11111, "uese_ch1");

    // Deselected: controls ignored.
    ijtag_sel = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk(K_SO, 0, 32'h0, "nosel_so");
    chk(K_SEL, 0, 32'h5, "nosel_sel");
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk(K_SEL, 0, 32'h5, "nosel_sel2");
    ijtag_sel = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk(K_SO, 0, 32'h1, "resel_so");

    // Reset in the middle of a load.
    shift5(5'b11010);
    upd();
    for (int c = 0; c < CH; c++) set_func(c, 19'h33333);
    chk(K_SEL, 0, 32'hA, "frz2_sel");
    chk(K_DAT, 1, 32'h11111, "frz2_ch1");
    chk(K_DAT, 0, 32'h22222, "frz2_ch0");
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    ijtag_reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    ijtag_reset = 1'b0;
    chk(K_SEL, 0, 32'h5, "mrst_sel");
    chk(K_SO, 0, 32'h1, "mrst_so");
    chk(K_DAT, 1, 32'h33333, "mrst_ch1");
    chk(K_DAT, 0, 32'h22222, "mrst_ch0");
    shift5(5'b01001);
    upd();
    chk(K_SEL, 0, 32'h9, "post_sel");
    chk(K_SO, 0, 32'h1, "post_so");
    chk(K_DAT, 3, 32'h22222, "post_ch3");
    chk(K_DAT, 1, 32'h33333, "post_ch1");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
